ps2_kbd_rx: RTL and testbench

PS/2 keyboard receiver that feeds the memory-mapped IO bus. It synchronises and filters the raw PS/2 clock and data lines and deserialises 11-bit frames. Valid scan-code bytes are buffered in a small FIFO. The head byte is presented on ps2_data toward the bus. The bus's ps2_done strobe pops one byte per strobe.

---
 rtl/ps2_kbd_rx.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines,
// deserialises 11-bit frames and queues valid scan codes in a FIFO that
// the IO bus pops with a rising edge on ps2_done.
`timescale 1ns/1ps
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int FILT       = 8,
    parameter int TIMEOUT    = 65536
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          ps2_done,
    output logic [7:0]                    ps2_data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int FW = $clog2(FILT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Input conditioning
    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;
    logic          filt_q, filt_prev_q;
    logic [FW-1:0] fcnt_q;
    logic          fall;

    // Frame FSM
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt_q;
    logic          frame_err_q;
    logic          push;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          done_q;
    logic          pop;
    logic          full;
    logic          wr_en;

    // Two-flop synchronisers; idle level of the PS/2 bus is high
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: follow the synchronised clock only after FILT differing samples in a row
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
        end else begin
            filt_prev_q <= filt_q;
            if (clk_s2_q == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FW'(FILT - 1)) begin
                filt_q <= clk_s2_q;
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_q;

    // A byte is accepted on the stop-bit sample when stop=1 and data+parity has odd weight
    assign push = fall && (state_q == STOP) && dat_s2_q && (^{shift_q, parity_q});

    // Frame deserialiser with inactivity timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (fall) begin
                to_cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= dat_s2_q;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (!(dat_s2_q && (^{shift_q, parity_q}))) begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE) begin
                if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_q     <= IDLE;
                    frame_err_q <= 1'b1;
                    to_cnt_q    <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    // Pop only on the rising edge of ps2_done; register resets high to block a pop right after reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q <= 1'b1;
        end else begin
            done_q <= ps2_done;
        end
    end

    assign full  = (count_q == LW'(FIFO_DEPTH));
    assign pop   = ps2_done && !done_q && (count_q != '0);
    // A push into a full FIFO still lands when a pop frees the head slot in the same cycle
    assign wr_en = push && (!full || pop);

    // FIFO pointer, occupancy and overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 1'b1;
        end
        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since the output is gated by ready
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign ready     = (count_q != '0);
    assign level     = count_q;
    assign ps2_data  = ready ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed testbench for ps2_kbd_rx with a byte scoreboard.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       ps2_done;
    logic [7:0] ps2_data;
    logic       ready;
    logic [3:0] level;
    logic       frame_err;
    logic       overflow;

    int unsigned vectors;
    int unsigned miscompares;

    logic [7:0] exp_q[$];
    logic       m_ovf;

    ps2_kbd_rx #(
        .FIFO_DEPTH (8),
        .FILT       (2),
        .TIMEOUT    (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .ps2_done  (ps2_done),
        .ps2_data  (ps2_data),
        .ready     (ready),
        .level     (level),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] head();
        return (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(exp_q.size()));
        chk({tag, "_ready"}, 32'(ready), 32'(exp_q.size() > 0));
        chk({tag, "_data"}, 32'(ps2_data), 32'(head()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One PS/2 bit: data set while clock high, then a 10-cycle low phase
    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame; optionally pulse ps2_done so the pop lands with the push
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit pop_mode);
        logic par;
        int   errs;
        int   err_at;
        bit   good;
        bit   do_pop;
        par  = bad_par ? (^b) : ~(^b);
        good = !bad_par && !bad_stop;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_dat = ~bad_stop;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        errs    = 0;
        err_at  = 0;
        do_pop  = pop_mode && (exp_q.size() > 0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (frame_err) begin
                errs++;
                err_at = c;
            end
            if (c == 4) begin
                chk("pre_push_level", 32'(level), 32'(exp_q.size()));
                if (pop_mode) begin
                    chk("pre_pop_head", 32'(ps2_data), 32'(head()));
                    ps2_done = 1'b1;
                end
            end
            if (c == 5) begin
                ps2_done = 1'b0;
                if (do_pop) void'(exp_q.pop_front());
                if (good) begin
                    if (exp_q.size() < 8) exp_q.push_back(b);
                    else m_ovf = 1'b1;
                end
                chk_state("post_stop");
            end
        end
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        chk("err_count", 32'(errs), good ? 32'd0 : 32'd1);
        if (!good) chk("err_cycle", 32'(err_at), 32'd5);
        repeat (10) @(negedge clk);
    endtask

    // Pop via ps2_done held high for 'hold' cycles; exactly one byte must leave
    task automatic pop_one(input int hold);
        chk("pop_head", 32'(ps2_data), 32'(head()));
        ps2_done = 1'b1;
        repeat (hold) @(negedge clk);
        ps2_done = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk_state("after_pop");
        @(negedge clk);
    endtask

    initial begin
        int errs;
        int err_at;
        vectors     = 0;
        miscompares = 0;
        m_ovf       = 1'b0;
        rst         = 1'b0;
        ps2_clk     = 1'b1;
        ps2_dat     = 1'b1;
        ps2_done    = 1'b0;
        repeat (3) @(negedge clk);
        chk_state("reset");
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 1: good frame then pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        pop_one(1);

        // 2: parity error, then stop-bit error
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);

        // 3: fill past capacity, then drain in order
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        chk("ovf_after_9", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) pop_one(1);
        chk_state("drained");

        // 4a: held ps2_done pops exactly once
        send_frame(8'h21, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        send_frame(8'h23, 1'b0, 1'b0, 1'b0);
        pop_one(5);
        chk("held_level", 32'(level), 32'd2);
        pop_one(1);
        pop_one(1);

        // 5: one-cycle glitch in IDLE with data low must not start a frame
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b1;
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (frame_err) errs++;
        end
        ps2_dat = 1'b1;
        chk("glitch_err", 32'(errs), 32'd0);
        chk_state("glitch");

        // 5: truncated frame times out
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        errs   = 0;
        err_at = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 10) ps2_clk = 1'b1;
            if (frame_err) begin
                errs++;
                err_at = c;
            end
        end
        chk("timeout_err", 32'(errs), 32'd1);
        chk("timeout_window", 32'((err_at >= 62) && (err_at <= 72)), 32'd1);
        chk_state("timeout");
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        pop_one(1);

        // 6: reset mid-frame with bytes queued and overflow still set
        send_frame(8'h41, 1'b0, 1'b0, 1'b0);
        send_frame(8'h42, 1'b0, 1'b0, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'((8'h1C >> i) & 8'h01));
        ps2_dat = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_ovf = 1'b0;
        chk_state("midframe_reset");
        ps2_dat = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'h32, 1'b0, 1'b0, 1'b0);

        // 4b: push and pop together while full, overflow clear beforehand
        for (int i = 0; i < 7; i++) send_frame(8'h51 + 8'(i), 1'b0, 1'b0, 1'b0);
        chk("full_level", 32'(level), 32'd8);
        send_frame(8'h58, 1'b0, 1'b0, 1'b1);
        chk("full_pushpop_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) pop_one(1);
        chk_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
